// File: rtl/buzzer_arbiter.sv
// Fixed-priority, preempting tone arbiter driving the keypad-lock buzzer pin.
// Define BUZZ_ARB_QUEUE_EN to queue lower-priority ok/fail/lock requests that arrive while busy.
module buzzer_arbiter #(
  parameter int HP_KEY    = 50000,
  parameter int HP_OK     = 25000,
  parameter int HP_FAIL   = 100000,
  parameter int HP_LOCK   = 12500,
  parameter int ON_KEY    = 10000000,
  parameter int ON_OK     = 30000000,
  parameter int ON_FAIL   = 5000000,
  parameter int ON_LOCK   = 5000000,
  parameter int OFF_LEN   = 5000000,
  parameter int LOCK_REPS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(HP_KEY, HP_OK), max2(HP_FAIL, HP_LOCK)),
                             max2(max2(max2(ON_KEY, ON_OK), max2(ON_FAIL, ON_LOCK)),
                                  max2(OFF_LEN, LOCK_REPS)));
  localparam int CW = $clog2(MAXP) + 1;
  localparam int BW = $clog2(LOCK_REPS + 1) + 1;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      id_q, id_d;
  logic            buzz_q, buzz_d;
  logic            done_q, done_d;
  logic [CW-1:0]   hp_q, hp_d;
  logic [CW-1:0]   dur_q, dur_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [3:0]      cand;
  logic [2:0]      sel;
  logic            start;

  function automatic logic [CW-1:0] hp_m1(input logic [1:0] id);
    case (id)
      2'd0:    return CW'(HP_KEY - 1);
      2'd1:    return CW'(HP_OK - 1);
      2'd2:    return CW'(HP_FAIL - 1);
      default: return CW'(HP_LOCK - 1);
    endcase
  endfunction

  function automatic logic [CW-1:0] on_m1(input logic [1:0] id);
    case (id)
      2'd0:    return CW'(ON_KEY - 1);
      2'd1:    return CW'(ON_OK - 1);
      2'd2:    return CW'(ON_FAIL - 1);
      default: return CW'(ON_LOCK - 1);
    endcase
  endfunction

  function automatic logic [BW-1:0] last_burst(input logic [1:0] id);
    case (id)
      2'd2:    return BW'(1);
      2'd3:    return BW'(LOCK_REPS - 1);
      default: return BW'(0);
    endcase
  endfunction

  // {valid, id} of the highest set request bit
  function automatic logic [2:0] pick(input logic [3:0] r);
    if (r[3])      return 3'b111;
    else if (r[2]) return 3'b110;
    else if (r[1]) return 3'b101;
    else if (r[0]) return 3'b100;
    else           return 3'b000;
  endfunction

`ifdef BUZZ_ARB_QUEUE_EN
  logic [3:0] pend_q, pend_d;

  // key clicks (bit 0) are never held; the started id leaves the queue
  always_comb begin
    pend_d = pend_q | (req & 4'b1110);
    if (stop)       pend_d = '0;
    else if (start) pend_d[sel[1:0]] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign cand = req | pend_q;
`else
  assign cand = req;
`endif

  assign sel   = pick((state_q == IDLE) ? cand : req);
  assign start = sel[2] && ((state_q == IDLE) || (sel[1:0] >= id_q));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    buzz_d  = buzz_q;
    hp_d    = hp_q;
    dur_d   = dur_q;
    burst_d = burst_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      id_d    = '0;
      buzz_d  = 1'b0;
      hp_d    = '0;
      dur_d   = '0;
      burst_d = '0;
    end else if (start) begin
      state_d = TONE;
      id_d    = sel[1:0];
      buzz_d  = 1'b1;
      hp_d    = '0;
      dur_d   = '0;
      burst_d = '0;
    end else begin
      case (state_q)
        TONE: begin
          if (dur_q == on_m1(id_q)) begin
            buzz_d = 1'b0;
            hp_d   = '0;
            dur_d  = '0;
            if (burst_q == last_burst(id_q)) begin
              state_d = IDLE;
              id_d    = '0;
              burst_d = '0;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            dur_d = dur_q + CW'(1);
            if (hp_q == hp_m1(id_q)) begin
              hp_d   = '0;
              buzz_d = ~buzz_q;
            end else begin
              hp_d = hp_q + CW'(1);
            end
          end
        end
        GAP: begin
          if (dur_q == CW'(OFF_LEN - 1)) begin
            state_d = TONE;
            buzz_d  = 1'b1;
            hp_d    = '0;
            dur_d   = '0;
            burst_d = burst_q + BW'(1);
          end else begin
            dur_d = dur_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      buzz_q  <= 1'b0;
      done_q  <= 1'b0;
      hp_q    <= '0;
      dur_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
      hp_q    <= hp_d;
      dur_q   <= dur_d;
      burst_q <= burst_d;
    end
  end

  assign buzzer    = buzz_q;
  assign busy      = (state_q != IDLE);
  assign active_id = id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter: per-cycle expected {buzzer,busy,active_id,done} go through a queue.
module tb_buzzer_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       stop;
  logic       buzzer, busy, done;
  logic [1:0] active_id;

  int checks = 0;
  int errors = 0;
  logic [4:0] expq[$];

  localparam int OFF = 5;

  buzzer_arbiter #(
    .HP_KEY(2), .HP_OK(1), .HP_FAIL(3), .HP_LOCK(1),
    .ON_KEY(8), .ON_OK(6), .ON_FAIL(6), .ON_LOCK(4),
    .OFF_LEN(OFF), .LOCK_REPS(3)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .stop(stop),
    .buzzer(buzzer), .busy(busy), .active_id(active_id), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic b, input logic bs, input logic [1:0] id, input logic d);
    expq.push_back({b, bs, id, d});
  endtask

  // tone cycles i in [from,to) of one burst: buzzer high for the first half-period
  task automatic push_tone(input logic [1:0] id, input int hp, input int from, input int to);
    for (int i = from; i < to; i++) push(((i / hp) % 2) == 0, 1'b1, id, 1'b0);
  endtask

  task automatic push_gap(input logic [1:0] id, input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, id, 1'b0);
  endtask

  task automatic push_idle(input int n, input logic d);
    push(1'b0, 1'b0, 2'd0, d);
    for (int i = 1; i < n; i++) push(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic chk_now(input string tag);
    logic [4:0] e, o;
    o = {buzzer, busy, active_id, done};
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %b but scoreboard empty", tag, o);
    end else begin
      e = expq.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed {buz,busy,id,done}=%b expected %b", tag, o, e);
      end
    end
  endtask

  task automatic run_q(input string tag);
    while (expq.size() > 0) begin
      @(posedge clk); #1;
      req  = 4'b0000;
      stop = 1'b0;
      chk_now(tag);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; stop = 1'b0;
    #3; push_idle(1, 1'b0); chk_now("reset");
    @(posedge clk); #1; push_idle(1, 1'b0); chk_now("reset_held");
    rst = 1'b0;

    // key click, single burst
    req = 4'b0001;
    push_tone(0, 2, 0, 8); push_idle(2, 1'b1);
    run_q("key");

    // fail: two bursts with a gap
    req = 4'b0100;
    push_tone(2, 3, 0, 6); push_gap(2, OFF); push_tone(2, 3, 0, 6); push_idle(2, 1'b1);
    run_q("fail");

    // lock preempts key at cycle 3, no done for key
    req = 4'b0001;
    push_tone(0, 2, 0, 3); run_q("pre_key");
    req = 4'b1000;
    push_tone(3, 1, 0, 4); push_gap(3, OFF); push_tone(3, 1, 0, 4); push_gap(3, OFF);
    push_tone(3, 1, 0, 4); push_idle(2, 1'b1);
    run_q("preempt");

    // all requests at once
    req = 4'b1111;
    push_tone(3, 1, 0, 4); push_gap(3, OFF); push_tone(3, 1, 0, 4); push_gap(3, OFF);
    push_tone(3, 1, 0, 4);
`ifdef BUZZ_ARB_QUEUE_EN
    push_idle(1, 1'b1);
    push_tone(2, 3, 0, 6); push_gap(2, OFF); push_tone(2, 3, 0, 6);
    push_idle(1, 1'b1);
    push_tone(1, 1, 0, 6);
    push_idle(3, 1'b1);
`else
    push_idle(3, 1'b1);
`endif
    run_q("all4");

    // same-id retrigger restarts the ok burst
    req = 4'b0010;
    push_tone(1, 1, 0, 3); run_q("ok_pre");
    req = 4'b0010;
    push_tone(1, 1, 0, 6); push_idle(2, 1'b1);
    run_q("retrig");

    // lower-priority key during lock is dropped in either build
    req = 4'b1000;
    push_tone(3, 1, 0, 2); run_q("lock_pre");
    req = 4'b0001;
    push_tone(3, 1, 2, 4); push_gap(3, OFF); push_tone(3, 1, 0, 4); push_gap(3, OFF);
    push_tone(3, 1, 0, 4); push_idle(3, 1'b1);
    run_q("drop_key");

    // stop with a simultaneous ok request during a fail gap, with ok also queued earlier
    req = 4'b0100;
    push_tone(2, 3, 0, 2); run_q("fail_pre");
    req = 4'b0010;
    push_tone(2, 3, 2, 6); push_gap(2, 2); run_q("fail_gap");
    stop = 1'b1; req = 4'b0010;
    push_idle(5, 1'b0);
    run_q("stop");

    // async reset mid-burst
    req = 4'b1000;
    push_tone(3, 1, 0, 2); run_q("lock_rst");
    #3; rst = 1'b1;
    #1; push_idle(1, 1'b0); chk_now("async_rst");
    #2; rst = 1'b0;
    push_idle(3, 1'b0);
    run_q("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
